ulpi_phy_emu: RTL and testbench

Synthesizable PHY-side responder for the ULPI bus: the other end from our link-side register initiator. It answers register write/read TX CMDs from the link, holds a small ULPI register file, and emits RX CMD bytes on line-state/VBUS changes. It is used as a loopback target in on-board link bring-up and as the DUT partner in link-side benches.

---
 rtl/ulpi_phy_emu.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_ulpi_phy_emu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_phy_emu.sv
// ulpi_phy_emu: PHY-side ULPI responder (register file, reg TX CMDs, RX CMD).
// Optional NXT wait states are enabled by defining ULPI_PHY_EMU_NXT_DELAY_EN.
module ulpi_phy_emu #(
  parameter logic [15:0] VID         = 16'h0424,
  parameter logic [15:0] PID         = 16'h0009,
  parameter int          STP_TIMEOUT = 8,
  parameter int          NXT_DELAY   = 2
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_DIR,
  output logic       ULPI_NXT,
  input  logic       ULPI_STP,
  input  logic [1:0] LINESTATE,
  input  logic [1:0] VBUS_STATE,
  output logic [7:0] FUNC_CTRL_O,
  output logic [7:0] OTG_CTRL_O,
  output logic [7:0] SCRATCH_O,
  output logic       ERR_TIMEOUT
);

  localparam int CMAX = (STP_TIMEOUT > NXT_DELAY) ? STP_TIMEOUT : NXT_DELAY;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [7:0] FUNC_RST = 8'h41;
  localparam logic [7:0] IFC_RST  = 8'h00;
  localparam logic [7:0] OTG_RST  = 8'h06;
  localparam logic [7:0] SCR_RST  = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_WAIT,
    S_W_NXT,
    S_W_DATA,
    S_W_STP,
    S_R_WAIT,
    S_R_NXT,
    S_R_TURN1,
    S_R_DATA,
    S_TURN_OUT,
    S_X_TURN1,
    S_X_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      addr_q, addr_d;
  logic [7:0]      wdat_q, wdat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [3:0]      last_q, last_d;
  logic [7:0]      func_q, func_d;
  logic [7:0]      ifc_q, ifc_d;
  logic [7:0]      otg_q, otg_d;
  logic [7:0]      scr_q, scr_d;
  logic [7:0]      dout_q, dout_d;
  logic            oe_q, oe_d;
  logic            dir_q, dir_d;
  logic            nxt_q, nxt_d;
  logic            err_q, err_d;

`ifdef ULPI_PHY_EMU_NXT_DELAY_EN
  logic [7:0]      cmd_q, cmd_d;
`endif

  logic [3:0]      cur;
  logic            chg;
  logic            tx_wr;
  logic            tx_rd;
  logic            commit;
  logic [7:0]      rdata;
  logic [3:0]      wsel;
  logic [1:0]      wop;
  logic [7:0]      wcur;
  logic [7:0]      wnew;

  assign cur   = {VBUS_STATE, LINESTATE};
  assign chg   = (cur != last_q);
  assign tx_wr = (ULPI_DATA_I[7:6] == 2'b10) && (ULPI_DATA_I[5:0] != 6'h2F);
  assign tx_rd = (ULPI_DATA_I[7:6] == 2'b11) && (ULPI_DATA_I[5:0] != 6'h2F);

  always_comb begin
    rdata = 8'h00;
    case (addr_q)
      6'h00:               rdata = VID[7:0];
      6'h01:               rdata = VID[15:8];
      6'h02:               rdata = PID[7:0];
      6'h03:               rdata = PID[15:8];
      6'h04, 6'h05, 6'h06: rdata = func_q;
      6'h07, 6'h08, 6'h09: rdata = ifc_q;
      6'h0A, 6'h0B, 6'h0C: rdata = otg_q;
      6'h16, 6'h17, 6'h18: rdata = scr_q;
      default:             rdata = 8'h00;
    endcase
  end

  // alias decode: op 0 = write, 1 = set, 2 = clear
  always_comb begin
    wsel = 4'b0000;
    wop  = 2'd0;
    case (addr_q)
      6'h04: begin wsel = 4'b0001; wop = 2'd0; end
      6'h05: begin wsel = 4'b0001; wop = 2'd1; end
      6'h06: begin wsel = 4'b0001; wop = 2'd2; end
      6'h07: begin wsel = 4'b0010; wop = 2'd0; end
      6'h08: begin wsel = 4'b0010; wop = 2'd1; end
      6'h09: begin wsel = 4'b0010; wop = 2'd2; end
      6'h0A: begin wsel = 4'b0100; wop = 2'd0; end
      6'h0B: begin wsel = 4'b0100; wop = 2'd1; end
      6'h0C: begin wsel = 4'b0100; wop = 2'd2; end
      6'h16: begin wsel = 4'b1000; wop = 2'd0; end
      6'h17: begin wsel = 4'b1000; wop = 2'd1; end
      6'h18: begin wsel = 4'b1000; wop = 2'd2; end
      default: begin wsel = 4'b0000; wop = 2'd0; end
    endcase
  end

  always_comb begin
    wcur = 8'h00;
    unique case (1'b1)
      wsel[0]: wcur = func_q;
      wsel[1]: wcur = ifc_q;
      wsel[2]: wcur = otg_q;
      wsel[3]: wcur = scr_q;
      default: wcur = 8'h00;
    endcase
  end

  always_comb begin
    wnew = wdat_q;
    case (wop)
      2'd1:    wnew = wcur | wdat_q;
      2'd2:    wnew = wcur & ~wdat_q;
      default: wnew = wdat_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | chg;
    last_d  = last_q;
    err_d   = 1'b0;
    commit  = 1'b0;
`ifdef ULPI_PHY_EMU_NXT_DELAY_EN
    cmd_d   = cmd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_wr) begin
          addr_d = ULPI_DATA_I[5:0];
`ifdef ULPI_PHY_EMU_NXT_DELAY_EN
          cmd_d   = ULPI_DATA_I;
          cnt_d   = '0;
          state_d = S_W_WAIT;
`else
          state_d = S_W_NXT;
`endif
        end else if (tx_rd) begin
          addr_d = ULPI_DATA_I[5:0];
`ifdef ULPI_PHY_EMU_NXT_DELAY_EN
          cmd_d   = ULPI_DATA_I;
          cnt_d   = '0;
          state_d = S_R_WAIT;
`else
          state_d = S_R_NXT;
`endif
        end else if ((pend_q | chg) && (ULPI_DATA_I == 8'h00) && !ULPI_STP) begin
          state_d = S_X_TURN1;
        end
      end
`ifdef ULPI_PHY_EMU_NXT_DELAY_EN
      S_W_WAIT, S_R_WAIT: begin
        if (ULPI_DATA_I != cmd_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(NXT_DELAY - 1)) begin
          state_d = (state_q == S_W_WAIT) ? S_W_NXT : S_R_NXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_W_NXT: state_d = S_W_DATA;
      S_W_DATA: begin
        wdat_d  = ULPI_DATA_I;
        cnt_d   = '0;
        state_d = S_W_STP;
      end
      S_W_STP: begin
        if (ULPI_STP) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(STP_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_R_NXT:    state_d = S_R_TURN1;
      S_R_TURN1:  state_d = S_R_DATA;
      S_R_DATA:   state_d = S_TURN_OUT;
      S_TURN_OUT: state_d = S_IDLE;
      S_X_TURN1: begin
        pend_d  = 1'b0;
        last_d  = cur;
        state_d = S_X_DATA;
      end
      S_X_DATA:   state_d = S_TURN_OUT;
      default:    state_d = S_IDLE;
    endcase
  end

  // bus outputs follow the state being entered so they are registered
  always_comb begin
    nxt_d  = (state_d == S_W_NXT) || (state_d == S_W_DATA) ||
             (state_d == S_R_NXT);
    dir_d  = (state_d == S_R_TURN1) || (state_d == S_R_DATA) ||
             (state_d == S_X_TURN1) || (state_d == S_X_DATA);
    oe_d   = (state_d == S_R_DATA) || (state_d == S_X_DATA);
    dout_d = 8'h00;
    if (state_d == S_R_DATA) begin
      dout_d = rdata;
    end else if (state_d == S_X_DATA) begin
      dout_d = {4'b0000, cur};
    end
  end

  always_comb begin
    func_d = func_q;
    ifc_d  = ifc_q;
    otg_d  = otg_q;
    scr_d  = scr_q;
    if (commit) begin
      if (wsel[0] && wnew[5]) begin
        func_d = FUNC_RST;
        ifc_d  = IFC_RST;
        otg_d  = OTG_RST;
        scr_d  = SCR_RST;
      end else begin
        if (wsel[0]) func_d = wnew;
        if (wsel[1]) ifc_d  = wnew;
        if (wsel[2]) otg_d  = wnew;
        if (wsel[3]) scr_d  = wnew;
      end
    end
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q <= S_IDLE;
      addr_q  <= 6'h00;
      wdat_q  <= 8'h00;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      last_q  <= 4'h0;
      func_q  <= FUNC_RST;
      ifc_q   <= IFC_RST;
      otg_q   <= OTG_RST;
      scr_q   <= SCR_RST;
      dout_q  <= 8'h00;
      oe_q    <= 1'b0;
      dir_q   <= 1'b0;
      nxt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      func_q  <= func_d;
      ifc_q   <= ifc_d;
      otg_q   <= otg_d;
      scr_q   <= scr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      dir_q   <= dir_d;
      nxt_q   <= nxt_d;
      err_q   <= err_d;
    end
  end

`ifdef ULPI_PHY_EMU_NXT_DELAY_EN
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      cmd_q <= 8'h00;
    end else begin
      cmd_q <= cmd_d;
    end
  end
`endif

  assign ULPI_DATA_O  = dout_q;
  assign ULPI_DATA_OE = oe_q;
  assign ULPI_DIR     = dir_q;
  assign ULPI_NXT     = nxt_q;
  assign FUNC_CTRL_O  = func_q;
  assign OTG_CTRL_O   = otg_q;
  assign SCRATCH_O    = scr_q;
  assign ERR_TIMEOUT  = err_q;

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// tb_ulpi_phy_emu: link-side driver plus register-file reference model
// for ulpi_phy_emu (default build, no NXT wait states).
module tb_ulpi_phy_emu;

  logic       CLK_60M = 1'b0;
  logic       NRST_A_USB;
  logic [7:0] ULPI_DATA_I;
  logic [7:0] ULPI_DATA_O;
  logic       ULPI_DATA_OE;
  logic       ULPI_DIR;
  logic       ULPI_NXT;
  logic       ULPI_STP;
  logic [1:0] LINESTATE;
  logic [1:0] VBUS_STATE;
  logic [7:0] FUNC_CTRL_O;
  logic [7:0] OTG_CTRL_O;
  logic [7:0] SCRATCH_O;
  logic       ERR_TIMEOUT;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] m_reg [4];
  int unsigned m_base [4] = '{4, 7, 10, 22};
  int unsigned alist [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9,
                              10, 11, 12, 22, 23, 24, 16, 63};

  always #5 CLK_60M = ~CLK_60M;

  ulpi_phy_emu dut (
    .CLK_60M      (CLK_60M),
    .NRST_A_USB   (NRST_A_USB),
    .ULPI_DATA_I  (ULPI_DATA_I),
    .ULPI_DATA_O  (ULPI_DATA_O),
    .ULPI_DATA_OE (ULPI_DATA_OE),
    .ULPI_DIR     (ULPI_DIR),
    .ULPI_NXT     (ULPI_NXT),
    .ULPI_STP     (ULPI_STP),
    .LINESTATE    (LINESTATE),
    .VBUS_STATE   (VBUS_STATE),
    .FUNC_CTRL_O  (FUNC_CTRL_O),
    .OTG_CTRL_O   (OTG_CTRL_O),
    .SCRATCH_O    (SCRATCH_O),
    .ERR_TIMEOUT  (ERR_TIMEOUT)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_reg[0] = 8'h41;
    m_reg[1] = 8'h00;
    m_reg[2] = 8'h06;
    m_reg[3] = 8'h00;
  endfunction

  function automatic logic [7:0] m_rd(input int unsigned a);
    logic [7:0] id [4];
    id[0] = 8'h24; id[1] = 8'h04; id[2] = 8'h09; id[3] = 8'h00;
    if (a < 4) return id[a];
    for (int i = 0; i < 4; i++)
      if (a >= m_base[i] && a < m_base[i] + 3) return m_reg[i];
    return 8'h00;
  endfunction

  function automatic void m_wr(input int unsigned a, input logic [7:0] d);
    logic [7:0] nv;
    for (int i = 0; i < 4; i++) begin
      if (a >= m_base[i] && a < m_base[i] + 3) begin
        if (a == m_base[i]) nv = d;
        else if (a == m_base[i] + 1) nv = m_reg[i] | d;
        else nv = m_reg[i] & ~d;
        if (i == 0 && nv[5]) m_reset();
        else m_reg[i] = nv;
      end
    end
  endfunction

  task automatic tick();
    @(posedge CLK_60M);
    #1;
  endtask

  task automatic wait_nxt(output logic ok, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ULPI_NXT && n < 8);
    ok = ULPI_NXT;
  endtask

  task automatic wait_oe(output logic [7:0] d, output logic ok, output int n);
    n = 0;
    ok = 1'b0;
    d = 8'h00;
    while (!ok && n < 12) begin
      tick();
      n++;
      if (ULPI_DIR && ULPI_DATA_OE) begin
        ok = 1'b1;
        d = ULPI_DATA_O;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_func"}, FUNC_CTRL_O, m_reg[0]);
    check({tag, "_otg"}, OTG_CTRL_O, m_reg[2]);
    check({tag, "_scr"}, SCRATCH_O, m_reg[3]);
  endtask

  task automatic link_wr(input logic [5:0] a, input logic [7:0] d,
                         input bit stp);
    logic ok;
    int n;
    ULPI_DATA_I = {2'b10, a};
    wait_nxt(ok, n);
    check("wr_nxt", ok, 1);
    check("wr_nxt_lat", n, 1);
    ULPI_DATA_I = d;
    n = 0;
    while (ULPI_NXT && n < 6) begin
      tick();
      n++;
    end
    check("wr_nxt_drop", ULPI_NXT, 0);
    ULPI_DATA_I = 8'h00;
    if (stp) begin
      ULPI_STP = 1'b1;
      tick();
      ULPI_STP = 1'b0;
      m_wr(a, d);
      check_regs("wr");
    end
  endtask

  task automatic link_rd(input logic [5:0] a, input logic [7:0] exp);
    logic ok;
    logic [7:0] d;
    int n;
    int lat;
    ULPI_DATA_I = {2'b11, a};
    wait_nxt(ok, n);
    check("rd_nxt", ok, 1);
    lat = n;
    ULPI_DATA_I = 8'h00;
    wait_oe(d, ok, n);
    check("rd_oe", ok, 1);
    check("rd_lat", lat + n, 3);
    check($sformatf("rd_%02h", a), d, exp);
    tick();
    check("rd_1cyc", {ULPI_DIR, ULPI_DATA_OE}, 0);
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic ok;
    int n;
    int errs;
    int unsigned a;
    NRST_A_USB  = 1'b0;
    ULPI_DATA_I = 8'h00;
    ULPI_STP    = 1'b0;
    LINESTATE   = 2'b00;
    VBUS_STATE  = 2'b00;
    m_reset();
    repeat (3) tick();
    check("rst_dir", ULPI_DIR, 0);
    check("rst_oe", ULPI_DATA_OE, 0);
    check("rst_nxt", ULPI_NXT, 0);
    check("rst_dout", ULPI_DATA_O, 0);
    check("rst_err", ERR_TIMEOUT, 0);
    check_regs("rst");
    #2 NRST_A_USB = 1'b1;
    tick();

    link_rd(6'h00, 8'h24);
    link_rd(6'h01, 8'h04);
    link_rd(6'h02, 8'h09);
    link_rd(6'h03, 8'h00);

    link_wr(6'h16, 8'hA5, 1);
    link_rd(6'h16, 8'hA5);
    link_wr(6'h17, 8'h0F, 1);
    link_wr(6'h18, 8'h81, 1);
    link_rd(6'h16, 8'h2E);

    link_wr(6'h16, 8'h55, 0);
    errs = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ERR_TIMEOUT) errs++;
    end
    check("to_pulses", errs, 1);
    check("to_scr", SCRATCH_O, 8'h2E);
    link_rd(6'h16, 8'h2E);

    LINESTATE = 2'b01;
    n = 0;
    while (!ULPI_DIR && n < 6) begin
      tick();
      n++;
    end
    check("rx_dir", ULPI_DIR, 1);
    check("rx_turn_oe", ULPI_DATA_OE, 0);
    tick();
    check("rx_data", {ULPI_DIR, ULPI_DATA_OE, ULPI_DATA_O}, 10'h301);
    tick();
    check("rx_rel", {ULPI_DIR, ULPI_DATA_OE}, 0);
    tick();

    LINESTATE = 2'b00;
    link_rd(6'h00, 8'h24);
    wait_oe(d, ok, n);
    check("rx2_ok", ok, 1);
    check("rx2_data", d, 8'h00);
    repeat (2) tick();

    ULPI_DATA_I = 8'hAF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ext_ign", {ULPI_DIR, ULPI_NXT}, 0);
    end
    ULPI_DATA_I = 8'h41;
    repeat (2) tick();
    check("cmd_ign", {ULPI_DIR, ULPI_NXT}, 0);
    ULPI_DATA_I = 8'h00;
    ULPI_STP = 1'b1;
    repeat (2) tick();
    check("stp_ign", {ULPI_DIR, ULPI_NXT}, 0);
    ULPI_STP = 1'b0;
    check_regs("ign");
    tick();

    for (int i = 0; i < 40; i++) begin
      a = alist[$urandom_range(0, 17)];
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) link_wr(6'(a), d, 1);
      else link_rd(6'(a), m_rd(a));
    end

    link_wr(6'h0A, 8'h3C, 1);
    link_wr(6'h16, 8'h11, 1);
    link_wr(6'h04, 8'h65, 1);
    check("frst_func", FUNC_CTRL_O, 8'h41);
    check("frst_otg", OTG_CTRL_O, 8'h06);
    check("frst_scr", SCRATCH_O, 8'h00);
    link_rd(6'h04, 8'h41);

    link_wr(6'h0A, 8'h99, 1);
    ULPI_DATA_I = 8'hCA;
    wait_nxt(ok, n);
    ULPI_DATA_I = 8'h00;
    wait_oe(d, ok, n);
    check("ar_rdata", ok, 1);
    #2 NRST_A_USB = 1'b0;
    #1;
    check("ar_dir", ULPI_DIR, 0);
    check("ar_oe", ULPI_DATA_OE, 0);
    check("ar_nxt", ULPI_NXT, 0);
    tick();
    #2 NRST_A_USB = 1'b1;
    m_reset();
    tick();
    check("ar_otg", OTG_CTRL_O, 8'h06);
    link_rd(6'h0A, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
